apb_slave: RTL and testbench

APB_SLAVE -- requirements
Module: apb_slave

---
 rtl/apb_slave_pkg.sv | 18 +
 rtl/apb_slave_mem.sv | 47 ++++
 rtl/apb_slave.sv | 100 ++++++++++
 tb/tb_apb_slave.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/apb_slave_pkg.sv
// -----------------------------------------------------------------------------
// apb_slave_pkg
// Shared declarations for the APB slave memory block:
//   - default address / data widths
//   - FSM state enumeration (IDLE, SETUP, ACCESS)
// -----------------------------------------------------------------------------
package apb_slave_pkg;

    localparam int unsigned ADDR_WIDTH_DEF = 32'd8;
    localparam int unsigned DATA_WIDTH_DEF = 32'd32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_e;

endpackage : apb_slave_pkg

// File: rtl/apb_slave_mem.sv
// -----------------------------------------------------------------------------
// apb_slave_mem
// 2**addrWidth x dataWidth storage array: synchronous write, asynchronous
// (combinational) read, asynchronous active-low clear of every word.
// Ports:
//   clk_i    : clock, write happens on the rising edge
//   rst_ni   : asynchronous active-low clear of the whole array
//   we_i     : write enable
//   waddr_i  : write word address
//   wdata_i  : write data
//   raddr_i  : read word address
//   rdata_o  : read data (combinational from raddr_i)
// -----------------------------------------------------------------------------
module apb_slave_mem
    import apb_slave_pkg::*;
#(
    parameter int unsigned addrWidth = ADDR_WIDTH_DEF,
    parameter int unsigned dataWidth = DATA_WIDTH_DEF
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 we_i,
    input  logic [addrWidth-1:0] waddr_i,
    input  logic [dataWidth-1:0] wdata_i,
    input  logic [addrWidth-1:0] raddr_i,
    output logic [dataWidth-1:0] rdata_o
);

    localparam int unsigned DEPTH = 32'd1 << addrWidth;

    logic [dataWidth-1:0] mem_q [DEPTH];

    // Storage update: whole-array clear on reset, single-word write otherwise.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Every address bit indexes the array directly, so there is no aliasing.
    assign rdata_o = mem_q[raddr_i];

endmodule : apb_slave_mem

// File: rtl/apb_slave.sv
// -----------------------------------------------------------------------------
// apb_slave
// Zero-wait-state, error-free APB slave in front of a word-addressed memory.
// Ports:
//   PCLK      : clock, all state changes on the rising edge
//   PRESENTn  : asynchronous active-low reset (FSM, prdata and memory)
//   PADDR     : word address
//   PWRITE    : 1 = write transfer, 0 = read transfer
//   PSELx     : slave select
//   PENABLE   : access-phase strobe
//   PWDATA    : write data
//   prdata    : registered read data, valid during the access phase
// -----------------------------------------------------------------------------
module apb_slave
    import apb_slave_pkg::*;
#(
    parameter int unsigned addrWidth = ADDR_WIDTH_DEF,
    parameter int unsigned dataWidth = DATA_WIDTH_DEF
) (
    input  logic                 PCLK,
    input  logic                 PRESENTn,
    input  logic [addrWidth-1:0] PADDR,
    input  logic                 PWRITE,
    input  logic                 PSELx,
    input  logic                 PENABLE,
    input  logic [dataWidth-1:0] PWDATA,
    output logic [dataWidth-1:0] prdata
);

    apb_state_e           state_q;
    logic [dataWidth-1:0] prdata_q;

    logic                 mem_we_s;
    logic                 rd_strobe_s;
    logic [dataWidth-1:0] mem_rdata_s;

    // A write commits only on the SETUP->ACCESS edge, so a write aborted in
    // SETUP or a strobe seen while still in IDLE never reaches memory.
    assign mem_we_s    = (state_q == SETUP) && PSELx && PENABLE && PWRITE;

    // Reads are captured at the end of every setup phase (including a SETUP
    // that is held and re-sampled) so prdata is stable through the access phase.
    assign rd_strobe_s = PSELx && !PENABLE && !PWRITE;

    apb_slave_mem #(
        .addrWidth (addrWidth),
        .dataWidth (dataWidth)
    ) u_mem (
        .clk_i   (PCLK),
        .rst_ni  (PRESENTn),
        .we_i    (mem_we_s),
        .waddr_i (PADDR),
        .wdata_i (PWDATA),
        .raddr_i (PADDR),
        .rdata_o (mem_rdata_s)
    );

    // Transfer FSM and registered read data.
    always_ff @(posedge PCLK or negedge PRESENTn) begin
        if (!PRESENTn) begin
            state_q  <= IDLE;
            prdata_q <= '0;
        end else begin
            if (rd_strobe_s) begin
                prdata_q <= mem_rdata_s;
            end

            case (state_q)
                IDLE: begin
                    // PENABLE without a preceding setup phase is ignored.
                    if (PSELx && !PENABLE) begin
                        state_q <= SETUP;
                    end
                end
                SETUP: begin
                    if (!PSELx) begin
                        state_q <= IDLE;
                    end else if (PENABLE) begin
                        state_q <= ACCESS;
                    end
                end
                ACCESS: begin
                    // Holding PSELx and PENABLE high extends ACCESS without
                    // starting another transfer.
                    if (!PSELx) begin
                        state_q <= IDLE;
                    end else if (!PENABLE) begin
                        state_q <= SETUP;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign prdata = prdata_q;

endmodule : apb_slave

// File: tb/tb_apb_slave.sv
// -----------------------------------------------------------------------------
// tb_apb_slave
// Directed bench for apb_slave. Expected read data comes from a reference
// memory image kept by the bench; each read pushes its expectation into a
// scoreboard queue that is popped when prdata is sampled in the access phase.
// -----------------------------------------------------------------------------
module tb_apb_slave;
    import apb_slave_pkg::*;

    logic        PCLK;
    logic        PRESENTn;
    logic [7:0]  PADDR;
    logic        PWRITE;
    logic        PSELx;
    logic        PENABLE;
    logic [31:0] PWDATA;
    logic [31:0] prdata;

    int          n_vec;
    int          n_miss;
    logic [31:0] model [0:255];
    logic [31:0] exp_q [$];
    logic [31:0] last_rd;

    apb_slave #(
        .addrWidth (8),
        .dataWidth (32)
    ) dut (
        .PCLK     (PCLK),
        .PRESENTn (PRESENTn),
        .PADDR    (PADDR),
        .PWRITE   (PWRITE),
        .PSELx    (PSELx),
        .PENABLE  (PENABLE),
        .PWDATA   (PWDATA),
        .prdata   (prdata)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < 256; i++) model[i] = 32'h0000_0000;
        last_rd = 32'h0000_0000;
    endtask

    task automatic go_idle();
        PSELx   = 1'b0;
        PENABLE = 1'b0;
        @(negedge PCLK);
    endtask

    // Write transfer; returns at the negedge after the access edge so the
    // caller may start another transfer back-to-back.
    task automatic apb_write(input logic [7:0] a, input logic [31:0] d);
        PSELx   = 1'b1;
        PENABLE = 1'b0;
        PWRITE  = 1'b1;
        PADDR   = a;
        PWDATA  = d;
        @(negedge PCLK);
        PENABLE = 1'b1;
        @(negedge PCLK);
        model[a] = d;
        check("write_keeps_prdata", prdata, last_rd);
    endtask

    task automatic apb_read(input logic [7:0] a, input string tag);
        logic [31:0] e;
        PSELx   = 1'b1;
        PENABLE = 1'b0;
        PWRITE  = 1'b0;
        PADDR   = a;
        exp_q.push_back(model[a]);
        @(negedge PCLK);
        e = exp_q.pop_front();
        check({tag, "_access"}, prdata, e);
        PENABLE = 1'b1;
        @(negedge PCLK);
        check({tag, "_hold"}, prdata, e);
        last_rd = e;
    endtask

    initial begin
        logic [31:0] e;
        n_vec    = 0;
        n_miss   = 0;
        PRESENTn = 1'b1;
        PSELx    = 1'b0;
        PENABLE  = 1'b0;
        PWRITE   = 1'b0;
        PADDR    = 8'h00;
        PWDATA   = 32'h0000_0000;
        clear_model();

        // Reset state
        #2 PRESENTn = 1'b0;
        repeat (3) @(negedge PCLK);
        check("reset_prdata", prdata, 32'h0000_0000);
        check("reset_state", 32'(dut.state_q), 32'(IDLE));
        PRESENTn = 1'b1;

        // Reads right after reset release: first SETUP on the next edge
        apb_read(8'h00, "rst_rd_00");
        apb_read(8'hFF, "rst_rd_FF");
        go_idle();

        // Write then read
        apb_write(8'h10, 32'hDEAD_BEEF);
        go_idle();
        apb_read(8'h10, "wr_rd_10");

        // Read set up on the cycle right after a write to the same address
        apb_write(8'h10, 32'h0F0F_0F0F);
        apb_read(8'h10, "raw_10");
        go_idle();

        // Back-to-back writes then back-to-back reads
        apb_write(8'h01, 32'h1111_1111);
        apb_write(8'h02, 32'h2222_2222);
        apb_read(8'h01, "b2b_rd_01");
        apb_read(8'h02, "b2b_rd_02");
        go_idle();

        // Aborted write: PSELx dropped during SETUP
        PSELx  = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1;
        PADDR  = 8'h20; PWDATA = 32'hCAFE_F00D;
        @(negedge PCLK);
        go_idle();
        apb_read(8'h20, "abort_rd_20");
        go_idle();

        // PENABLE with PSELx while in IDLE (no setup phase) must not write
        PSELx  = 1'b1; PENABLE = 1'b1; PWRITE = 1'b1;
        PADDR  = 8'h40; PWDATA = 32'hBAD0_0040;
        repeat (2) @(negedge PCLK);
        go_idle();
        apb_read(8'h40, "idle_en_rd_40");
        go_idle();

        // Extended ACCESS: changed PWDATA during the held access is not written
        apb_write(8'h50, 32'h600D_600D);
        PWDATA = 32'hBAD0_BAD0;
        @(negedge PCLK);
        go_idle();
        apb_read(8'h50, "ext_acc_rd_50");
        go_idle();

        // SETUP held with PENABLE low re-samples the new address
        PSELx = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 8'h10;
        @(negedge PCLK);
        PADDR = 8'h01;
        exp_q.push_back(model[8'h01]);
        @(negedge PCLK);
        e = exp_q.pop_front();
        check("resample_rd_01", prdata, e);
        PENABLE = 1'b1;
        @(negedge PCLK);
        last_rd = e;
        go_idle();

        // Boundary addresses
        apb_write(8'hFF, 32'hA5A5_A5A5);
        apb_write(8'h00, 32'h5A5A_5A5A);
        apb_read(8'hFF, "bnd_rd_FF");
        apb_read(8'h00, "bnd_rd_00");
        go_idle();

        // Reset during a later SETUP
        apb_write(8'h30, 32'h1234_5678);
        go_idle();
        apb_read(8'h30, "pre_rst_rd_30");
        go_idle();
        PSELx  = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1;
        PADDR  = 8'h30; PWDATA = 32'h8765_4321;
        @(negedge PCLK);
        PENABLE  = 1'b1;
        PRESENTn = 1'b0;
        #1;
        check("midrst_prdata", prdata, 32'h0000_0000);
        check("midrst_state", 32'(dut.state_q), 32'(IDLE));
        repeat (2) @(negedge PCLK);
        PSELx    = 1'b0;
        PENABLE  = 1'b0;
        PRESENTn = 1'b1;
        clear_model();
        check("post_rst_state", 32'(dut.state_q), 32'(IDLE));
        apb_read(8'h30, "post_rst_rd_30");
        apb_read(8'h10, "post_rst_rd_10");
        apb_read(8'hFF, "post_rst_rd_FF");
        go_idle();

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule : tb_apb_slave
